af6cesrtl_gapsched: RTL and testbench
=====================================

# af6cesrtl_gapsched

Paced consumer sitting directly downstream of the gap buffer. It pops one request at a time from the buffer's `oreq`/`oreqinfo`/`iget` interface and holds it as a registered valid/ready beat toward the next stage. It then enforces a programmable idle gap before popping the next one. Two status counters support flow-control debug.

## Interface
Parameters:
- `INFO`, 32, request info width (matches the gap buffer `INFO`)
- `GAPW`, 8, width of the gap configuration and gap counter
- `CNTW`, 16, width of the status counters

Ports:
- `clk`  input  1  single clock
- `rst`  input  1  asynchronous, active-low reset
- `ireq`  input  1  request pending from the gap buffer (its `oreq`)
- `ireqinfo`  input  INFO  request info (its `oreqinfo`); valid while `ireq`=1
- `oget`  output  1  pop strobe to the gap buffer (its `iget`)
- `enable`  input  1  permits new pops; does not abort an item in flight
- `flush`  input  1  synchronous flush of the scheduler
- `cfggap`  input  GAPW  idle cycles inserted after each accepted beat
- `ovld`  output  1  beat valid to downstream
- `oinfo`  output  INFO  beat data
- `irdy`  input  1  downstream ready
- `obusy`  output  1  high whenever state is not IDLE
- `osent`  output  CNTW  accepted-beat counter, wraps
- `ostall`  output  CNTW  cycles with `ovld`=1 and `irdy`=0, saturates at all-ones

## Operation
States: IDLE, SEND, GAP (2-bit encoded).
- IDLE:
  - `oget` = `rst` & `enable` & `ireq` & !`flush` (combinational).
  - When `oget`=1: capture `ireqinfo` into `oinfo` and go to SEND.
- SEND:
  - `ovld`=1.
  - On `ovld`&`irdy`: increment `osent` (modulo 2^CNTW).
  - Then, if `cfggap`==0, go to IDLE. Otherwise load the gap counter with `cfggap` and go to GAP.
  - `cfggap` is sampled only on that transition.
- GAP:
  - Decrement the counter each cycle.
  - When the counter reaches 1, go to IDLE, so exactly `cfggap` cycles are spent in GAP.
  - `oget` is 0 throughout GAP.
- `ostall` increments in every SEND cycle with `irdy`=0 and holds at 2^CNTW-1.
- `flush`=1 (any state):
  - Next state is IDLE and `ovld` drops.
  - A held beat is discarded and is not counted in `osent`.
  - The gap counter is cleared.
  - `osent` and `ostall` keep their values.
  - `oget` is suppressed in a flush cycle.
- `enable`=0:
  - Blocks IDLE→SEND only.
  - SEND and GAP run to completion.
- `oinfo` changes only on capture. It holds its last value in IDLE and GAP.
- Reset (`rst`=0, asynchronous) mid-operation:
  - state=IDLE, `ovld`=0, `oinfo`=0, `osent`=0, `ostall`=0, gap counter=0.
  - `oget`=0, `obusy`=0.
  - No beat is delivered after reset release unless a new pop occurs.

## Timing
- A pop in cycle T gives `ovld`=1 with the captured `oinfo` from cycle T+1.
- A handshake at T+1 with `cfggap`=0 returns to IDLE at T+2.
  - Because the buffer's `oreq` drops in the cycle after `iget`, peak throughput is one beat per 2 cycles.
- With `cfggap`=G, the minimum spacing between consecutive `oget` pulses is 2+G cycles.
- `oget` is a single-cycle pulse; it is never high on two consecutive cycles.
- `ovld` is never deasserted without a handshake, except by `flush` or reset. `oinfo` is stable while `ovld`=1 and `irdy`=0.
- `obusy` is registered and equals (state≠IDLE).

## Test plan
- `cfggap`=0, `irdy`=1, buffer preloaded with 4 items A..D: `oget` pulses at T, T+2, T+4, T+6. `ovld` carries A..D at T+1, T+3, T+5, T+7. `osent`=4.
- `cfggap`=3, `irdy`=1, 2 items: `oget` pulses at T and T+5, with GAP occupying T+2..T+4. `osent`=2.
- `irdy` held 0 for 5 cycles after `ovld` rises with item 0xDEADBEEF: `oinfo` stays 0xDEADBEEF and `ostall`=5. The handshake occurs on the first `irdy`=1 cycle, then `osent`=1.
- `flush` asserted during SEND (`irdy`=0): `ovld`=0 next cycle and `osent` is unchanged. The next `ireq` is popped in the first cycle with `flush`=0.
- `enable` dropped while in GAP with `ireq`=1: the gap completes and `oget` stays 0 while `enable`=0. The first `oget` occurs in the cycle `enable` returns to 1.
- `rst` pulled low asynchronously mid-SEND with CNTW counters nonzero: all outputs are 0 immediately. After `ostall` reaches 0xFFFF with CNTW=16, a further stall keeps it at 0xFFFF.

Source files
------------

// File: rtl/af6cesrtl_gapsched.sv
// Paced consumer behind the gap buffer: pops one request, presents it as a registered
// beat, then enforces a programmable idle gap before the next pop.
module af6cesrtl_gapsched #(
    parameter int INFO = 32,
    parameter int GAPW = 8,
    parameter int CNTW = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ireq,
    input  logic [INFO-1:0] ireqinfo,
    output logic            oget,
    input  logic            enable,
    input  logic            flush,
    input  logic [GAPW-1:0] cfggap,
    output logic            ovld,
    output logic [INFO-1:0] oinfo,
    input  logic            irdy,
    output logic            obusy,
    output logic [CNTW-1:0] osent,
    output logic [CNTW-1:0] ostall,
    output logic [1:0]      ostate
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEND = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

    localparam logic [CNTW-1:0] CNT_MAX = '1;
    localparam logic [GAPW-1:0] GAP_ONE = GAPW'(1);

    logic [1:0]      state;
    logic [1:0]      state_nxt;
    logic [GAPW-1:0] gap_cnt;
    logic [GAPW-1:0] gap_nxt;
    logic            fire;

    // Downstream handshake: a beat transfers in a cycle where ovld and irdy are both
    // high. Once raised, ovld stays high with oinfo stable until that transfer; only
    // flush or reset may withdraw a beat early.
    assign fire   = ovld & irdy;
    assign oget   = rst & enable & ireq & ~flush & (state == ST_IDLE);
    assign ostate = state;

    always_comb begin
        state_nxt = state;
        gap_nxt   = gap_cnt;
        if (flush) begin
            state_nxt = ST_IDLE;
            gap_nxt   = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (oget) state_nxt = ST_SEND;
                end
                ST_SEND: begin
                    if (irdy) begin
                        if (cfggap == '0) begin
                            state_nxt = ST_IDLE;
                        end else begin
                            state_nxt = ST_GAP;
                            gap_nxt   = cfggap;
                        end
                    end
                end
                ST_GAP: begin
                    // Leaving on a count of 1 makes the gap exactly cfggap cycles long.
                    if (gap_cnt <= GAP_ONE) begin
                        state_nxt = ST_IDLE;
                        gap_nxt   = '0;
                    end else begin
                        gap_nxt = gap_cnt - GAP_ONE;
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                    gap_nxt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ST_IDLE;
            gap_cnt <= '0;
            ovld    <= 1'b0;
            obusy   <= 1'b0;
            oinfo   <= '0;
            osent   <= '0;
            ostall  <= '0;
        end else begin
            state   <= state_nxt;
            gap_cnt <= gap_nxt;
            ovld    <= (state_nxt == ST_SEND);
            obusy   <= (state_nxt != ST_IDLE);
            if (oget) oinfo <= ireqinfo;
            // A beat discarded by flush never counts as sent.
            if (fire && !flush) osent <= osent + 1'b1;
            if (ovld && !irdy && (ostall != CNT_MAX)) ostall <= ostall + 1'b1;
        end
    end

endmodule

// File: tb/tb_af6cesrtl_gapsched.sv
// Bench for af6cesrtl_gapsched: gap-buffer source model, transaction-level reference,
// directed scenarios from the block's timing rules, then randomized traffic.
module tb_af6cesrtl_gapsched;

    logic        clk;
    logic        rst;
    logic        ireq;
    logic [31:0] ireqinfo;
    logic        oget;
    logic        enable;
    logic        flush;
    logic [7:0]  cfggap;
    logic        ovld;
    logic [31:0] oinfo;
    logic        irdy;
    logic        obusy;
    logic [15:0] osent;
    logic [15:0] ostall;
    logic [1:0]  ostate;

    int checks   = 0;
    int failures = 0;

    af6cesrtl_gapsched #(.INFO(32), .GAPW(8), .CNTW(16)) dut (
        .clk(clk), .rst(rst), .ireq(ireq), .ireqinfo(ireqinfo), .oget(oget),
        .enable(enable), .flush(flush), .cfggap(cfggap), .ovld(ovld), .oinfo(oinfo),
        .irdy(irdy), .obusy(obusy), .osent(osent), .ostall(ostall), .ostate(ostate)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Gap buffer source: request drops for one cycle after each pop.
    logic [31:0] mem [0:255];
    logic [7:0]  wr_ptr = 8'd0;
    logic [7:0]  rd_ptr = 8'd0;
    logic        just_popped = 1'b0;

    assign ireq     = (wr_ptr != rd_ptr) && !just_popped;
    assign ireqinfo = mem[rd_ptr];

    always @(posedge clk) begin
        just_popped <= oget;
        if (oget) rd_ptr <= rd_ptr + 8'd1;
    end

    task automatic push(input logic [31:0] d);
        mem[wr_ptr] = d;
        wr_ptr = wr_ptr + 8'd1;
    endtask

    // Reference: "holding a beat" plus "gap cycles still owed".
    logic        m_holding;
    logic [31:0] m_data;
    logic [7:0]  m_gap;
    logic [15:0] m_sent;
    logic [15:0] m_stall;
    logic        exp_oget;
    logic        exp_busy;

    assign exp_oget = rst && enable && ireq && !flush && !m_holding && (m_gap == 8'd0);
    assign exp_busy = m_holding || (m_gap != 8'd0);

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_holding <= 1'b0;
            m_data    <= '0;
            m_gap     <= '0;
            m_sent    <= '0;
            m_stall   <= '0;
        end else begin
            if (m_holding && !irdy && m_stall != 16'hFFFF) m_stall <= m_stall + 16'd1;
            if (flush) begin
                m_holding <= 1'b0;
                m_gap     <= '0;
            end else if (m_holding) begin
                if (irdy) begin
                    m_sent    <= m_sent + 16'd1;
                    m_holding <= 1'b0;
                    m_gap     <= cfggap;
                end
            end else if (m_gap != 8'd0) begin
                m_gap <= m_gap - 8'd1;
            end else if (exp_oget) begin
                m_holding <= 1'b1;
                m_data    <= ireqinfo;
            end
        end
    end

    task automatic test_reset;
        rst = 1'b0; enable = 1'b1; flush = 1'b0; cfggap = 8'd0; irdy = 1'b0;
        push(32'hA000_000A);
        repeat (2) @(negedge clk);
        #1;
        checks++; if (oget !== 1'b0) begin failures++; $display("FAIL reset_oget: got %b expected 0", oget); end
        checks++; if (ovld !== 1'b0) begin failures++; $display("FAIL reset_ovld: got %b expected 0", ovld); end
        checks++; if (oinfo !== 32'd0) begin failures++; $display("FAIL reset_oinfo: got %h expected 0", oinfo); end
        checks++; if (osent !== 16'd0 || ostall !== 16'd0) begin failures++; $display("FAIL reset_counters: got sent=%h stall=%h expected 0", osent, ostall); end
        checks++; if (obusy !== 1'b0) begin failures++; $display("FAIL reset_obusy: got %b expected 0", obusy); end
        @(negedge clk);
        enable = 1'b0;
        rst = 1'b1;
    endtask

    task automatic test_back_to_back;
        int pulses[$];
        int vcyc[$];
        logic [31:0] vdat[$];
        logic [31:0] exp_d [4];
        exp_d = '{32'hA000_000A, 32'hB000_000B, 32'hC000_000C, 32'hD000_000D};
        cfggap = 8'd0; irdy = 1'b1;
        push(32'hB000_000B); push(32'hC000_000C); push(32'hD000_000D);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i == 0) enable = 1'b1;
            #1;
            if (oget) pulses.push_back(i);
            if (ovld) begin vcyc.push_back(i); vdat.push_back(oinfo); end
        end
        checks++; if (pulses.size() != 4 || vcyc.size() != 4) begin failures++; $display("FAIL b2b_count: got pops=%0d beats=%0d expected 4/4", pulses.size(), vcyc.size()); end
        for (int k = 0; k < 4; k++) begin
            if (k < pulses.size() && k < vcyc.size()) begin
                checks++; if (pulses[k] != 2 * k) begin failures++; $display("FAIL b2b_pop_cycle: got %0d expected %0d", pulses[k], 2 * k); end
                checks++; if (vcyc[k] != 2 * k + 1 || vdat[k] !== exp_d[k]) begin failures++; $display("FAIL b2b_beat: got cyc=%0d data=%h expected cyc=%0d data=%h", vcyc[k], vdat[k], 2 * k + 1, exp_d[k]); end
            end
        end
        checks++; if (osent !== 16'd4) begin failures++; $display("FAIL b2b_osent: got %0d expected 4", osent); end
    endtask

    task automatic test_gap;
        int pulses[$];
        cfggap = 8'd3; irdy = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (i == 0) begin push(32'hE000_000E); push(32'hF000_000F); end
            #1;
            if (oget) pulses.push_back(i);
            if (i >= 2 && i <= 4) begin
                checks++; if (obusy !== 1'b1 || ovld !== 1'b0) begin failures++; $display("FAIL gap_hold: cyc %0d got busy=%b vld=%b expected 1/0", i, obusy, ovld); end
            end
            if (i == 11) begin
                checks++; if (obusy !== 1'b0) begin failures++; $display("FAIL gap_idle: got %b expected 0", obusy); end
            end
        end
        checks++; if (pulses.size() != 2 || pulses[0] != 0 || pulses[1] != 5) begin failures++; $display("FAIL gap_pops: got n=%0d first=%0d second=%0d expected 2 at 0,5", pulses.size(), pulses.size() > 0 ? pulses[0] : -1, pulses.size() > 1 ? pulses[1] : -1); end
        checks++; if (osent !== 16'd6) begin failures++; $display("FAIL gap_osent: got %0d expected 6", osent); end
    endtask

    task automatic test_stall;
        cfggap = 8'd0; irdy = 1'b0;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            if (i == 0) push(32'hDEAD_BEEF);
            if (i == 6) irdy = 1'b1;
            #1;
            if (i == 0) begin
                checks++; if (oget !== 1'b1) begin failures++; $display("FAIL stall_pop: got %b expected 1", oget); end
            end
            if (i >= 1 && i <= 6) begin
                checks++; if (ovld !== 1'b1 || oinfo !== 32'hDEAD_BEEF) begin failures++; $display("FAIL stall_hold: cyc %0d got vld=%b info=%h expected 1/deadbeef", i, ovld, oinfo); end
            end
            if (i == 6) begin
                checks++; if (ostall !== 16'd5) begin failures++; $display("FAIL stall_count: got %0d expected 5", ostall); end
            end
            if (i == 7) begin
                checks++; if (osent !== 16'd7 || ovld !== 1'b0) begin failures++; $display("FAIL stall_done: got sent=%0d vld=%b expected 7/0", osent, ovld); end
            end
        end
    endtask

    task automatic test_flush;
        irdy = 1'b0; cfggap = 8'd0;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            if (i == 0) begin push(32'h1111_0001); push(32'h2222_0002); end
            flush = (i == 1 || i == 2);
            irdy  = (i >= 4);
            #1;
            if (i == 1) begin
                checks++; if (ovld !== 1'b1 || oget !== 1'b0) begin failures++; $display("FAIL flush_send: got vld=%b get=%b expected 1/0", ovld, oget); end
            end
            if (i == 2) begin
                checks++; if (ovld !== 1'b0 || oget !== 1'b0) begin failures++; $display("FAIL flush_drop: got vld=%b get=%b expected 0/0", ovld, oget); end
            end
            if (i == 3) begin
                checks++; if (oget !== 1'b1 || osent !== 16'd7) begin failures++; $display("FAIL flush_repop: got get=%b sent=%0d expected 1/7", oget, osent); end
            end
            if (i == 4) begin
                checks++; if (ovld !== 1'b1 || oinfo !== 32'h2222_0002) begin failures++; $display("FAIL flush_next: got vld=%b info=%h expected 1/22220002", ovld, oinfo); end
            end
            if (i == 6) begin
                checks++; if (osent !== 16'd8) begin failures++; $display("FAIL flush_osent: got %0d expected 8", osent); end
            end
        end
        flush = 1'b0;
    endtask

    task automatic test_enable;
        cfggap = 8'd4; irdy = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (i == 0) begin push(32'h3333_0003); push(32'h4444_0004); end
            enable = !(i >= 2 && i <= 7);
            #1;
            if (i >= 2 && i <= 7) begin
                checks++; if (oget !== 1'b0) begin failures++; $display("FAIL enable_block: cyc %0d got %b expected 0", i, oget); end
            end
            if (i == 5) begin
                checks++; if (obusy !== 1'b1) begin failures++; $display("FAIL enable_gap_runs: got %b expected 1", obusy); end
            end
            if (i == 6) begin
                checks++; if (obusy !== 1'b0) begin failures++; $display("FAIL enable_gap_done: got %b expected 0", obusy); end
            end
            if (i == 8) begin
                checks++; if (oget !== 1'b1) begin failures++; $display("FAIL enable_resume: got %b expected 1", oget); end
            end
            if (i == 9) begin
                checks++; if (oinfo !== 32'h4444_0004) begin failures++; $display("FAIL enable_beat: got %h expected 44440004", oinfo); end
            end
        end
        cfggap = 8'd0;
    endtask

    task automatic test_random;
        logic prev_get;
        prev_get = 1'b0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 2) == 0 && (wr_ptr - rd_ptr) < 8'd20) push($urandom);
            irdy   = ($urandom_range(0, 3) != 0);
            enable = ($urandom_range(0, 7) != 0);
            flush  = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 15) == 0) cfggap = 8'($urandom_range(0, 5));
            #1;
            checks++; if (oget !== exp_oget) begin failures++; $display("FAIL rand_oget: cyc %0d got %b expected %b", i, oget, exp_oget); end
            checks++; if (ovld !== m_holding || (ovld && oinfo !== m_data)) begin failures++; $display("FAIL rand_beat: cyc %0d got vld=%b info=%h expected %b/%h", i, ovld, oinfo, m_holding, m_data); end
            checks++; if (osent !== m_sent || ostall !== m_stall) begin failures++; $display("FAIL rand_counters: cyc %0d got %0d/%0d expected %0d/%0d", i, osent, ostall, m_sent, m_stall); end
            checks++; if (obusy !== exp_busy) begin failures++; $display("FAIL rand_obusy: cyc %0d got %b expected %b", i, obusy, exp_busy); end
            checks++; if (prev_get && oget) begin failures++; $display("FAIL rand_oget_pulse: cyc %0d got two consecutive pops expected single pulse", i); end
            prev_get = oget;
        end
    endtask

    task automatic test_async_reset;
        int n;
        enable = 1'b1; flush = 1'b0; irdy = 1'b1; cfggap = 8'd0;
        n = 0;
        while ((wr_ptr != rd_ptr || obusy) && n < 300) begin
            @(negedge clk); #1; n++;
        end
        checks++; if (n >= 300) begin failures++; $display("FAIL drain_timeout: got %0d cycles expected < 300", n); end
        @(negedge clk);
        irdy = 1'b0;
        push(32'h5555_0005);
        #1;
        checks++; if (oget !== 1'b1) begin failures++; $display("FAIL areset_pop: got %b expected 1", oget); end
        @(negedge clk); #1;
        checks++; if (ovld !== 1'b1 || osent !== m_sent || m_sent == 16'd0) begin failures++; $display("FAIL areset_pre: got vld=%b sent=%0d expected 1/%0d nonzero", ovld, osent, m_sent); end
        #2 rst = 1'b0;
        #1;
        checks++; if (ovld !== 1'b0 || oinfo !== 32'd0 || oget !== 1'b0 || obusy !== 1'b0) begin failures++; $display("FAIL areset_outputs: got vld=%b info=%h get=%b busy=%b expected all 0", ovld, oinfo, oget, obusy); end
        checks++; if (osent !== 16'd0 || ostall !== 16'd0) begin failures++; $display("FAIL areset_counters: got %0d/%0d expected 0/0", osent, ostall); end
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            checks++; if (ovld !== 1'b0 || oget !== 1'b0) begin failures++; $display("FAIL areset_quiet: cyc %0d got vld=%b get=%b expected 0/0", i, ovld, oget); end
        end
    endtask

    task automatic test_saturate;
        int n;
        irdy = 1'b0; enable = 1'b1; cfggap = 8'd0;
        @(negedge clk);
        push(32'h6666_0006);
        n = 0;
        while (ostall !== 16'hFFFF && n < 70000) begin
            @(negedge clk); #1; n++;
        end
        checks++; if (n >= 70000 || m_stall !== 16'hFFFF) begin failures++; $display("FAIL sat_reach: got stall=%h after %0d cycles expected ffff", ostall, n); end
        @(negedge clk); #1;
        checks++; if (ostall !== 16'hFFFF || ovld !== 1'b1 || oinfo !== 32'h6666_0006) begin failures++; $display("FAIL sat_hold: got stall=%h vld=%b info=%h expected ffff/1/66660006", ostall, ovld, oinfo); end
        @(negedge clk);
        irdy = 1'b1;
        @(negedge clk); #1;
        checks++; if (osent !== 16'd1 || ovld !== 1'b0 || ostall !== 16'hFFFF) begin failures++; $display("FAIL sat_release: got sent=%0d vld=%b stall=%h expected 1/0/ffff", osent, ovld, ostall); end
    endtask

    initial begin
        test_reset;
        test_back_to_back;
        test_gap;
        test_stall;
        test_flush;
        test_enable;
        test_random;
        test_async_reset;
        test_saturate;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
